// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and result helpers for the EX-stage multiply/divide unit.
// Result helpers are pure functions of the latched operands.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic md_div_by_zero(md_op_e op, logic [31:0] b);
    logic dz;
    dz = 1'b0;
    if (((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0)) begin
      dz = 1'b1;
    end else begin
      dz = 1'b0;
    end
    return dz;
  endfunction

  // Returns {HI, LO}; signed divide works on magnitudes so INT_MIN/-1 wraps cleanly.
  function automatic logic [63:0] md_result(md_op_e op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    p  = 64'd0;
    ua = a;
    ub = b;
    q  = 32'd0;
    r  = 32'd0;
    case (op)
      MD_MULT:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: p = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        ua = a[31] ? (32'd0 - a) : a;
        ub = b[31] ? (32'd0 - b) : b;
        if (ub != 32'd0) begin
          q = ua / ub;
          r = ua % ub;
        end else begin
          q = 32'd0;
          r = 32'd0;
        end
        q = (a[31] ^ b[31]) ? (32'd0 - q) : q;
        r = a[31] ? (32'd0 - r) : r;
        p = {r, q};
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          q = a / b;
          r = a % b;
        end else begin
          q = 32'd0;
          r = 32'd0;
        end
        p = {r, q};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Operand/command and HI/LO result bundle between the EX stage and the mul/div unit.
interface ex_muldiv_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, output MDOp, output A, output B,
                  input Busy, input HI, input LO);
  modport slave  (input Start, input MDOp, input A, input B,
                  output Busy, output HI, output LO);
endinterface

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: owns HI/LO, fixed-latency mult/div, Busy for the hazard unit.
// Results are computed from latched operands and committed only on the final RUN edge.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  ex_muldiv_if.slave     bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state_r;
  md_op_e            op_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [31:0]       a_r;
  logic [31:0]       b_r;
  logic [31:0]       hi_r;
  logic [31:0]       lo_r;
  logic              busy_r;
  md_op_e            op_in_s;
  logic [63:0]       res_s;
  logic              div_zero_s;

  assign op_in_s    = md_op_e'(bus.MDOp);
  assign res_s      = md_result(op_r, a_r, b_r);
  assign div_zero_s = md_div_by_zero(op_r, b_r);

  assign bus.Busy = busy_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;

  // Control FSM, operand latches, latency counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      op_r    <= MD_NONE;
      cnt_r   <= '0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.Start) begin
            case (op_in_s)
              MD_MULT, MD_MULTU: begin
                a_r     <= bus.A;
                b_r     <= bus.B;
                op_r    <= op_in_s;
                cnt_r   <= CNT_W'(MULT_CYCLES);
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                a_r     <= bus.A;
                b_r     <= bus.B;
                op_r    <= op_in_s;
                cnt_r   <= CNT_W'(DIV_CYCLES);
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
              end
              MD_MTHI: hi_r <= bus.A;
              MD_MTLO: lo_r <= bus.A;
              default: ;
            endcase
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // Start/MDOp are deliberately ignored here; the hazard unit keeps ID stalled.
          if (cnt_r == CNT_W'(1)) begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            if (!div_zero_s) begin
              hi_r <= res_s[63:32];
              lo_r <= res_s[31:0];
            end else begin
              hi_r <= hi_r;
              lo_r <= lo_r;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- EX-stage multiply/divide unit in the five-stage MIPS pipeline.
- Consumes the RD1/RD2 operands and the decoded multiply/divide operation that the ID/EX register delivers into EX.
- Holds the architectural HI/LO registers and models fixed multi-cycle latency.
- Exposes Busy so the hazard unit can stall any later mult/div/mfhi/mflo/mthi/mtlo in ID.

Parameters:
- MULT_CYCLES, 5, cycles from the accepted start to HI/LO valid for mult/multu.
- DIV_CYCLES, 10, cycles from the accepted start to HI/LO valid for div/divu.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  qualifies MDOp this cycle; driven from the EX-stage instruction.
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  forwarded rs operand (EX-stage RD1).
- B  input  32  forwarded rt operand (EX-stage RD2).
- Busy  output  1  high while a mult/div is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. On a reset edge: Busy=0, HI=0, LO=0, cycle counter=0, state=IDLE. Reset abandons any in-flight operation.
- States: IDLE and RUN.
- Accept rule: an operation is accepted only when state=IDLE and Start=1 at a rising edge. In RUN, Start/MDOp are ignored; the hazard unit guarantees none arrive.
- IDLE, MDOp 1-4 accepted:
  - Latch A and B into internal operand registers at the edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; Busy=1 from the next cycle.
- IDLE, MDOp 5 (mthi) accepted: HI<=A at the edge. Single cycle, Busy stays 0.
- IDLE, MDOp 6 (mtlo) accepted: LO<=A at the edge. Single cycle, Busy stays 0.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter goes 1->0: write HI/LO, return to IDLE. Busy falls in the same cycle HI/LO show the new values.
  - Net effect: with Start sampled at edge T0, Busy is high for exactly N cycles, and HI/LO are valid from edge T0+N onward.
- Arithmetic is computed from the latched operands, so later changes on A/B during RUN have no effect.
  - mult: signed 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits.
  - multu: unsigned 32x32 to 64; same HI/LO split.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
- Divide by zero: operation still takes DIV_CYCLES and Busy behaves normally; HI and LO are left unchanged.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
- HI/LO outputs are registered and reflect committed values only; no partial results are visible during RUN.
- Reset asserted in the same cycle as Start: reset wins and nothing is accepted.

Decomposition:
- Shared package/header (alongside the existing ALUOp encodings):
  - MDOp encoding constants MD_NONE..MD_MTLO.
  - Default latency constants.
- A one-line decode of MDOp from the instruction belongs in the existing ctrl decode, not in this block.
- No sub-module: the multiply/divide result is a combinational function of the latched operands, registered at completion. Total RTL fits in one module.

Test Plan:
- Reset, then mult with A=0xFFFFFFFE (-2), B=3, Start at T0 -> Busy high for 5 cycles; at T0+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- multu with A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2 -> Busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Same A/B with divu -> LO=0x7FFFFFFC, HI=0x00000001.
- mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0 -> HI/LO update one edge each, Busy never rises. Then divu with B=0 -> 10 busy cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- Start a div, toggle A/B and pulse Start with MDOp=mthi during RUN -> the mthi is ignored, and the result matches the originally latched operands.
- Assert reset at cycle 3 of a div -> next cycle Busy=0, HI=0, LO=0. A mult started right after completes normally in 5 cycles.
